// File: rtl/nand_lib_pkg.sv
// Shared constants and types for the NAND-built gate-level library.
// Command encoding here is used by every sequential block's priority decoder.
package nand_lib_pkg;

  localparam int   MAX_WIDTH = 32;
  localparam logic COUNT_UP  = 1'b0;
  localparam logic COUNT_DN  = 1'b1;

  typedef enum logic [1:0] {
    CMD_HOLD,
    CMD_COUNT,
    CMD_LOAD,
    CMD_CLR
  } cmd_t;

endpackage

// File: rtl/nand_incdec.sv
// Combinational WIDTH-bit +1 / -1 ripple built only from 2-input NAND gates.
// Carry (up) and borrow (down) share one chain: bit i propagates when a[i] differs from dn.
module nand_incdec #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic             dn,
  output logic [WIDTH-1:0] y
);

  wire [WIDTH-1:0] y_w;
  wire [WIDTH-1:1] c;
  wire [WIDTH-2:0] t;

  // Bit 0 always toggles.
  nand u_inv0 (y_w[0], a[0], a[0]);

  genvar i;
  for (i = 0; i < WIDTH - 1; i++) begin : g_prop
    wire n1, n2, n3;
    nand u_x1 (n1, a[i], dn);
    nand u_x2 (n2, a[i], n1);
    nand u_x3 (n3, dn, n1);
    nand u_x4 (t[i], n2, n3);
  end

  assign c[1] = t[0];

  for (i = 2; i < WIDTH; i++) begin : g_chain
    wire nc;
    nand u_a1 (nc, t[i-1], c[i-1]);
    nand u_a2 (c[i], nc, nc);
  end

  for (i = 1; i < WIDTH; i++) begin : g_sum
    wire s1, s2, s3;
    nand u_s1 (s1, a[i], c[i]);
    nand u_s2 (s2, a[i], s1);
    nand u_s3 (s3, c[i], s1);
    nand u_s4 (y_w[i], s2, s3);
  end

  assign y = y_w;

endmodule

// File: rtl/nand_counter.sv
// Loadable up/down counter with selectable modulus, wrap/saturate mode,
// terminal-count pulse, sticky overflow and out-of-range load flag.
module nand_counter
  import nand_lib_pkg::*;
#(
  parameter int             WIDTH     = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter bit             WRAP      = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             dn,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             ld_err
);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("nand_counter: WIDTH out of range");
  end
  if (RESET_VAL > MAX_VAL) begin : g_bad_reset
    $error("nand_counter: RESET_VAL exceeds MAX_VAL");
  end

  cmd_t             cmd;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;
  logic             ld_err_nxt;
  logic             at_max;
  logic             at_zero;
  logic             at_edge;

  nand_incdec #(.WIDTH(WIDTH)) u_incdec (
    .a  (q),
    .dn (dn),
    .y  (step_q)
  );

  always_comb begin
    cmd = CMD_HOLD;
    if (clr)     cmd = CMD_CLR;
    else if (ld) cmd = CMD_LOAD;
    else if (en) cmd = CMD_COUNT;
  end

  // Boundary is an explicit compare so non-power-of-two moduli wrap correctly.
  assign at_max  = (q == MAX_VAL);
  assign at_zero = (q == '0);
  assign at_edge = (dn == COUNT_UP) ? at_max : at_zero;

  always_comb begin
    q_nxt      = q;
    tc_nxt     = 1'b0;
    ovf_nxt    = ovf;
    ld_err_nxt = 1'b0;
    case (cmd)
      CMD_CLR: begin
        q_nxt   = '0;
        ovf_nxt = 1'b0;
      end
      CMD_LOAD: begin
        ovf_nxt = 1'b0;
        if (d > MAX_VAL) begin
          q_nxt      = MAX_VAL;
          ld_err_nxt = 1'b1;
        end else begin
          q_nxt = d;
        end
      end
      CMD_COUNT: begin
        if (at_edge) begin
          tc_nxt  = 1'b1;
          ovf_nxt = 1'b1;
          if (WRAP) q_nxt = (dn == COUNT_DN) ? MAX_VAL : '0;
        end else begin
          q_nxt = step_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= RESET_VAL;
      tc     <= 1'b0;
      ovf    <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      q      <= q_nxt;
      tc     <= tc_nxt;
      ovf    <= ovf_nxt;
      ld_err <= ld_err_nxt;
    end
  end

endmodule

// File: tb/tb_nand_counter.sv
// Bench for nand_counter: directed table, corner sequences, random run against
// an arithmetic reference model, and an exhaustive sweep of nand_incdec.
module tb_nand_counter;

  typedef struct {
    int q;
    int tc;
    int ovf;
    int ld_err;
  } ms_t;

  typedef struct {
    int clr, ld, d, en, dn;
    int q, tc, ovf, ld_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, ld, en, dn;
  logic [3:0] d4;
  logic [7:0] d8;

  logic [3:0] q_w, q_s;
  logic [7:0] q_f;
  logic       tc_w, ovf_w, lde_w;
  logic       tc_s, ovf_s, lde_s;
  logic       tc_f, ovf_f, lde_f;

  logic [7:0] id_a, id_y;
  logic       id_dn;

  int n_vec = 0;
  int n_bad = 0;
  ms_t m_w, m_s, m_f;
  vec_t vt[25];

  always #5 clk = ~clk;

  nand_counter #(.WIDTH(4), .MAX_VAL(4'd9), .WRAP(1'b1), .RESET_VAL(4'd0)) dut_w (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .d(d4), .en(en), .dn(dn),
    .q(q_w), .tc(tc_w), .ovf(ovf_w), .ld_err(lde_w));

  nand_counter #(.WIDTH(4), .MAX_VAL(4'd9), .WRAP(1'b0), .RESET_VAL(4'd0)) dut_s (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .d(d4), .en(en), .dn(dn),
    .q(q_s), .tc(tc_s), .ovf(ovf_s), .ld_err(lde_s));

  nand_counter #(.WIDTH(8), .MAX_VAL(8'd255), .WRAP(1'b1), .RESET_VAL(8'd0)) dut_f (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .d(d8), .en(en), .dn(dn),
    .q(q_f), .tc(tc_f), .ovf(ovf_f), .ld_err(lde_f));

  nand_incdec #(.WIDTH(8)) u_id (.a(id_a), .dn(id_dn), .y(id_y));

  function automatic ms_t model_reset();
    ms_t r;
    r.q = 0; r.tc = 0; r.ovf = 0; r.ld_err = 0;
    return r;
  endfunction

  // Counting is modular arithmetic on integers over 0..maxv.
  function automatic ms_t step(ms_t s, int c, int l, int dv, int e, int down,
                               int maxv, int wrap);
    ms_t n = s;
    n.tc = 0;
    n.ld_err = 0;
    if (c != 0) begin
      n.q = 0; n.ovf = 0;
    end else if (l != 0) begin
      n.ovf = 0;
      if (dv > maxv) begin n.q = maxv; n.ld_err = 1; end
      else n.q = dv;
    end else if (e != 0) begin
      if (down == 0) begin
        if (s.q == maxv) begin n.tc = 1; n.ovf = 1; end
        n.q = (wrap != 0) ? (s.q + 1) % (maxv + 1) : ((s.q < maxv) ? s.q + 1 : s.q);
      end else begin
        if (s.q == 0) begin n.tc = 1; n.ovf = 1; end
        n.q = (wrap != 0) ? (s.q + maxv) % (maxv + 1) : ((s.q > 0) ? s.q - 1 : s.q);
      end
    end
    return n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_models();
    chk("w.q", 32'(q_w), m_w.q);   chk("w.tc", 32'(tc_w), m_w.tc);
    chk("w.ovf", 32'(ovf_w), m_w.ovf); chk("w.lde", 32'(lde_w), m_w.ld_err);
    chk("s.q", 32'(q_s), m_s.q);   chk("s.tc", 32'(tc_s), m_s.tc);
    chk("s.ovf", 32'(ovf_s), m_s.ovf); chk("s.lde", 32'(lde_s), m_s.ld_err);
    chk("f.q", 32'(q_f), m_f.q);   chk("f.tc", 32'(tc_f), m_f.tc);
    chk("f.ovf", 32'(ovf_f), m_f.ovf); chk("f.lde", 32'(lde_f), m_f.ld_err);
  endtask

  task automatic cycle(int c, int l, int dv4, int dv8, int e, int down);
    clr = 1'(c); ld = 1'(l); d4 = 4'(dv4); d8 = 8'(dv8); en = 1'(e); dn = 1'(down);
    @(posedge clk);
    m_w = step(m_w, c, l, dv4, e, down, 9, 1);
    m_s = step(m_s, c, l, dv4, e, down, 9, 0);
    m_f = step(m_f, c, l, dv8, e, down, 255, 1);
    #1;
    chk_models();
  endtask

  // Assert reset between edges and check the outputs drop without a clock.
  task automatic async_reset();
    rst_n = 1'b0;
    m_w = model_reset(); m_s = model_reset(); m_f = model_reset();
    #1;
    chk_models();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 0; ld = 0; en = 0; dn = 0; d4 = 0; d8 = 0;
    id_a = 0; id_dn = 0;
    m_w = model_reset(); m_s = model_reset(); m_f = model_reset();

    //        clr ld  d  en dn |  q tc ovf lde
    vt = '{
      '{0, 0, 0, 1, 0,   1, 0, 0, 0}, '{0, 0, 0, 1, 0,   2, 0, 0, 0},
      '{0, 0, 0, 1, 0,   3, 0, 0, 0}, '{0, 0, 0, 1, 0,   4, 0, 0, 0},
      '{0, 0, 0, 1, 0,   5, 0, 0, 0}, '{0, 0, 0, 1, 0,   6, 0, 0, 0},
      '{0, 0, 0, 1, 0,   7, 0, 0, 0}, '{0, 0, 0, 1, 0,   8, 0, 0, 0},
      '{0, 0, 0, 1, 0,   9, 0, 0, 0}, '{0, 0, 0, 1, 0,   0, 1, 1, 0},
      '{0, 0, 0, 1, 0,   1, 0, 1, 0}, '{0, 0, 0, 1, 0,   2, 0, 1, 0},
      '{0, 1, 15, 0, 0,  9, 0, 0, 1}, '{0, 0, 0, 0, 0,   9, 0, 0, 0},
      '{0, 1, 5, 0, 0,   5, 0, 0, 0}, '{1, 1, 7, 1, 0,   0, 0, 0, 0},
      '{0, 1, 7, 1, 0,   7, 0, 0, 0}, '{0, 0, 0, 1, 1,   6, 0, 0, 0},
      '{0, 1, 0, 0, 0,   0, 0, 0, 0}, '{0, 0, 0, 1, 1,   9, 1, 1, 0},
      '{0, 0, 0, 1, 1,   8, 0, 1, 0}, '{0, 0, 0, 0, 0,   8, 0, 1, 0},
      '{0, 1, 9, 1, 0,   9, 0, 0, 0}, '{0, 0, 0, 1, 0,   0, 1, 1, 0},
      '{1, 0, 0, 0, 0,   0, 0, 0, 0}
    };

    repeat (2) @(posedge clk);
    #1;
    chk_models();
    @(negedge clk);
    rst_n = 1'b1;

    // Count a few cycles, then reset mid-count.
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 0);
    chk("mid.q_before", 32'(q_w), 5);
    async_reset();
    chk("mid.q_after", 32'(q_w), 0);

    for (int i = 0; i < 25; i++) begin
      cycle(vt[i].clr, vt[i].ld, vt[i].d, vt[i].d, vt[i].en, vt[i].dn);
      chk($sformatf("tbl%0d.q", i), 32'(q_w), vt[i].q);
      chk($sformatf("tbl%0d.tc", i), 32'(tc_w), vt[i].tc);
      chk($sformatf("tbl%0d.ovf", i), 32'(ovf_w), vt[i].ovf);
      chk($sformatf("tbl%0d.lde", i), 32'(lde_w), vt[i].ld_err);
    end

    // Saturating count down through zero.
    cycle(0, 1, 2, 2, 0, 0);
    chk("sat.ld", 32'(q_s), 2);
    cycle(0, 0, 0, 0, 1, 1);
    chk("sat1.q", 32'(q_s), 1); chk("sat1.tc", 32'(tc_s), 0);
    cycle(0, 0, 0, 0, 1, 1);
    chk("sat2.q", 32'(q_s), 0); chk("sat2.tc", 32'(tc_s), 0);
    cycle(0, 0, 0, 0, 1, 1);
    chk("sat3.q", 32'(q_s), 0); chk("sat3.tc", 32'(tc_s), 1); chk("sat3.ovf", 32'(ovf_s), 1);
    cycle(0, 0, 0, 0, 1, 1);
    chk("sat4.q", 32'(q_s), 0); chk("sat4.tc", 32'(tc_s), 1); chk("sat4.ovf", 32'(ovf_s), 1);

    // Full-range wrap on the 8-bit instance.
    cycle(0, 1, 15, 255, 0, 0);
    chk("full.ld", 32'(q_f), 255);
    cycle(0, 0, 0, 0, 1, 0);
    chk("full.up.q", 32'(q_f), 0); chk("full.up.tc", 32'(tc_f), 1);
    cycle(0, 0, 0, 0, 1, 1);
    chk("full.dn.q", 32'(q_f), 255); chk("full.dn.tc", 32'(tc_f), 1);

    // Random run against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      cycle(($urandom_range(0, 15) == 0) ? 1 : 0,
            ($urandom_range(0, 7) == 0) ? 1 : 0,
            int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
            ($urandom_range(0, 3) != 0) ? 1 : 0,
            int'($urandom_range(0, 1)));
    end

    // Exhaustive +/-1 sweep of the NAND ripple.
    for (int a = 0; a < 256; a++) begin
      for (int k = 0; k < 2; k++) begin
        id_a = 8'(a);
        id_dn = 1'(k);
        #1;
        chk($sformatf("incdec a=%0d dn=%0d", a, k), 32'(id_y),
            (k == 0) ? (a + 1) % 256 : (a + 255) % 256);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
